// File: rtl/demux_feed_sequencer.sv
// rtl/demux_feed_sequencer.sv - column/row tagging feeder for the systolic-array output demux
// Optional abort input and logic are built only when DEMUX_SEQ_ABORT_EN is defined.
module demux_feed_sequencer #(
  parameter int SELECT_WIDTH = 5,
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_OUTPUTS  = 32,
  parameter int ROW_COUNT    = 32,
  parameter int ROW_WIDTH    = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
`ifdef DEMUX_SEQ_ABORT_EN
  input  logic                         abort,
`endif
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic [SELECT_WIDTH-1:0]      select,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  output logic [ROW_WIDTH-1:0]         row_index,
  output logic                         busy,
  output logic                         done
);

  localparam logic [SELECT_WIDTH-1:0] COL_LAST = SELECT_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [ROW_WIDTH-1:0]    ROW_LAST = ROW_WIDTH'(ROW_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [SELECT_WIDTH-1:0] col_cnt;
  logic [ROW_WIDTH-1:0]    row_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      in_ready  <= 1'b0;
      select    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      row_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            col_cnt  <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
`ifdef DEMUX_SEQ_ABORT_EN
          // Abort takes priority over any beat in the same cycle, including the last one.
          if (abort) begin
            state    <= IDLE;
            col_cnt  <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end else
`endif
          if (in_valid && in_ready) begin
            out_data  <= in_data;
            select    <= col_cnt;
            row_index <= row_cnt;
            out_valid <= 1'b1;
            if (col_cnt == COL_LAST) begin
              col_cnt <= '0;
              if (row_cnt == ROW_LAST) begin
                state    <= DONE;
                in_ready <= 1'b0;
                busy     <= 1'b0;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // The pulse lands in the cycle after the final word is presented.
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_feed_sequencer.sv
// tb/tb_demux_feed_sequencer.sv - randomized scoreboard bench for demux_feed_sequencer
module tb_demux_feed_sequencer;

  localparam int NCOL  = 32;
  localparam int NROW  = 32;
  localparam int FRAME = NCOL * NROW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic              in_ready;
  logic [4:0]        select;
  logic signed [15:0] out_data;
  logic              out_valid;
  logic [4:0]        row_index;
  logic              busy;
  logic              done;

  demux_feed_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef DEMUX_SEQ_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .select(select),
    .out_data(out_data),
    .out_valid(out_valid),
    .row_index(row_index),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int sel;
    int row;
  } beat_t;

  typedef enum int { M_IDLE, M_LOAD, M_DONE } mode_t;

  beat_t exp_q[$];
  mode_t mode = M_IDLE;
  int    beats = 0;
  bit    exp_done = 0;
  bit    exp_valid = 0;
  int    done_cnt = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  int    last_sel = 0;
  int    last_data = 0;
  int    last_row = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  // Reference: a frame is just a count of accepted words; word k goes to column k%NCOL, row k/NCOL.
  task automatic step(input bit s, input bit v, input int d, input bit a);
    bit a_en;
    beat_t b;
    start = s; in_valid = v; in_data = 16'(d); abort = a;
`ifdef DEMUX_SEQ_ABORT_EN
    a_en = a;
`else
    a_en = 1'b0;
`endif
    chk("in_ready", int'(in_ready), int'(mode == M_LOAD));
    chk("busy", int'(busy), int'(mode == M_LOAD));
    @(posedge clk);
    exp_done = (mode == M_DONE);
    exp_valid = 0;
    case (mode)
      M_IDLE: if (s) begin mode = M_LOAD; beats = 0; end
      M_LOAD: begin
        if (a_en) mode = M_IDLE;
        else if (v) begin
          b.data = int'($signed(16'(d)));
          b.sel = beats % NCOL;
          b.row = beats / NCOL;
          exp_q.push_back(b);
          exp_valid = 1;
          beats++;
          if (beats == FRAME) mode = M_DONE;
        end
      end
      default: mode = M_IDLE;
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 0; in_valid = 0; abort = 0;
    reset = 1'b1;
    #1;
    chk("rst_select", int'(select), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_row_index", int'(row_index), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    mode = M_IDLE; beats = 0; exp_done = 0; exp_valid = 0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int frame_word(input int k);
    if (k == NCOL - 1) return -1;
    if (k == NCOL) return -32768;
    return int'($signed(16'($urandom)));
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      last_sel = 0; last_data = 0; last_row = 0;
    end else begin
      chk("done", int'(done), int'(exp_done));
      chk("out_valid", int'(out_valid), int'(exp_valid));
      if (done) done_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", int'(out_data), e.data);
          chk("select", int'(select), e.sel);
          chk("row_index", int'(row_index), e.row);
        end
        last_sel = int'(select); last_data = int'(out_data); last_row = int'(row_index);
      end else begin
        chk("select_hold", int'(select), last_sel);
        chk("data_hold", int'(out_data), last_data);
        chk("row_hold", int'(row_index), last_row);
      end
    end
  end

  initial begin
    int d0;
    int guard;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 7, 1);

    // Sequential frame 0..1023 with valid held high.
    d0 = done_cnt;
    step(1, 0, 0, 0);
    for (int k = 0; k < FRAME; k++) step(0, 1, k, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 99, 0);
    chk("done_count_frame1", done_cnt - d0, 1);

    // Start held every cycle, explicit 1,0,0,1 bubbles then random bubbles.
    d0 = done_cnt;
    step(1, 0, 0, 0);
    guard = 0;
    while (mode == M_LOAD && guard < 8000) begin
      bit v;
      if (guard < 4) v = (guard == 0 || guard == 3);
      else v = ($urandom_range(0, 3) != 0);
      step(1, v, frame_word(beats), 0);
      guard++;
    end
    chk("frame2_completed", int'(mode == M_DONE), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("done_count_frame2", done_cnt - d0, 1);

    // Reset in the middle of a frame, then a fresh frame restarts at column 0, row 0.
    d0 = done_cnt;
    step(1, 0, 0, 0);
    for (int k = 0; k < 500; k++) step(0, 1, frame_word(k), 0);
    do_reset();
    for (int i = 0; i < 2; i++) step(0, 1, 5, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 40; k++) step(0, 1, frame_word(k), 0);
`ifdef DEMUX_SEQ_ABORT_EN
    step(0, 1, 1234, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int k = 0; k < FRAME - 1; k++) step(0, 1, frame_word(k), 0);
    step(0, 1, 4321, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
`else
    do_reset();
`endif
    chk("done_count_aborted", done_cnt - d0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
